// File: rtl/maze_pkg.sv
// Shared types for the maze walker: heading codes, controller states, decision actions
// and the 90-degree rotation helpers.
package maze_pkg;

    typedef enum logic [2:0] {
        ORI_N = 3'b000,
        ORI_E = 3'b001,
        ORI_S = 3'b010,
        ORI_W = 3'b011
    } orient_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_STUCK = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE   = 3'd0,
        ACT_ADV    = 3'd1,
        ACT_TURN_L = 3'd2,
        ACT_TURN_R = 3'd3,
        ACT_REMOVE = 3'd4
    } action_t;

    // Consecutive clockwise turns without an advance that mean a dead end
    localparam logic [2:0] STUCK_TURNS = 3'd4;

    function automatic orient_t rot_ccw(input orient_t h);
        case (h)
            ORI_N:   rot_ccw = ORI_W;
            ORI_E:   rot_ccw = ORI_N;
            ORI_S:   rot_ccw = ORI_E;
            ORI_W:   rot_ccw = ORI_S;
            default: rot_ccw = ORI_N;
        endcase
    endfunction

    function automatic orient_t rot_cw(input orient_t h);
        case (h)
            ORI_N:   rot_cw = ORI_E;
            ORI_E:   rot_cw = ORI_S;
            ORI_S:   rot_cw = ORI_W;
            ORI_W:   rot_cw = ORI_N;
            default: rot_cw = ORI_N;
        endcase
    endfunction

endpackage

// File: rtl/maze_walker_if.sv
// Sensor/actuator bundle between the maze walker (slave) and the map/actuator layer (master).
interface maze_walker_if #(
    parameter int X_W = 3,
    parameter int Y_W = 3
) ();
    logic           start;
    logic           head;
    logic           left;
    logic           under;
    logic           barreira;
    logic           avancar;
    logic           girar;
    logic           girar_esq;
    logic           remover;
    logic [2:0]     orientacao;
    logic [X_W-1:0] pos_x;
    logic [Y_W-1:0] pos_y;
    logic           busy;
    logic           done;
    logic           stuck;

    modport slave (
        input  start, head, left, under, barreira,
        output avancar, girar, girar_esq, remover, orientacao, pos_x, pos_y, busy, done, stuck
    );

    modport master (
        output start, head, left, under, barreira,
        input  avancar, girar, girar_esq, remover, orientacao, pos_x, pos_y, busy, done, stuck
    );
endinterface

// File: rtl/step_timer.sv
// Decision-step divider: tick is high on the last cycle of every STEP_DIV-cycle window
// while enabled; the count restarts from zero whenever enable drops.
module step_timer #(
    parameter int STEP_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    output logic tick
);
    localparam int CW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Window counter, wraps on the tick cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = enable && (r_cnt == LAST);
endmodule

// File: rtl/maze_walker.sv
// Left-hand wall-following maze controller: one decision per step tick, registered
// one-cycle action pulses, grid position/heading tracking, goal and dead-end detection.
module maze_walker
    import maze_pkg::*;
#(
    parameter int X_W      = 3,
    parameter int Y_W      = 3,
    parameter int GOAL_X   = 7,
    parameter int GOAL_Y   = 7,
    parameter int STEP_DIV = 4
) (
    input  logic          clock,
    input  logic          reset,
    maze_walker_if.slave  bus
);
    localparam logic [X_W-1:0] GX    = X_W'(GOAL_X);
    localparam logic [Y_W-1:0] GY    = Y_W'(GOAL_Y);
    localparam logic [X_W-1:0] X_MAX = {X_W{1'b1}};
    localparam logic [Y_W-1:0] Y_MAX = {Y_W{1'b1}};

    state_t         r_state, w_state;
    orient_t        r_ori, w_ori;
    logic [X_W-1:0] r_x, w_x, w_tgt_x;
    logic [Y_W-1:0] r_y, w_y, w_tgt_y;
    logic           r_last_left, w_last_left;
    logic [2:0]     r_turn_cnt, w_turn_cnt, w_turn_inc;
    logic           r_avancar, w_avancar;
    logic           r_girar, w_girar;
    logic           r_girar_esq, w_girar_esq;
    logic           r_remover, w_remover;
    logic           r_busy, w_busy;
    logic           r_done, w_done;
    logic           r_stuck, w_stuck;
    logic           w_tick;
    action_t        w_action;

    step_timer #(.STEP_DIV(STEP_DIV)) u_step_timer (
        .clock  (clock),
        .reset  (reset),
        .enable (r_state == ST_RUN),
        .tick   (w_tick)
    );

    // Left-hand rule; a cell beyond the grid edge counts as a wall
    function automatic action_t decide(input logic i_head, input logic i_left,
                                       input logic i_under, input logic i_barr,
                                       input orient_t h, input logic [X_W-1:0] x,
                                       input logic [Y_W-1:0] y, input logic ll);
        logic in_range;
        case (h)
            ORI_N:   in_range = (y != Y_MAX);
            ORI_E:   in_range = (x != X_MAX);
            ORI_S:   in_range = (y != '0);
            ORI_W:   in_range = (x != '0);
            default: in_range = 1'b0;
        endcase
        if (i_under) begin
            decide = ACT_REMOVE;
        end else if (!i_left && !ll) begin
            decide = ACT_TURN_L;
        end else if (!i_head && !i_barr && in_range) begin
            decide = ACT_ADV;
        end else begin
            decide = ACT_TURN_R;
        end
    endfunction

    // Sensor decision and the cell one step ahead
    always_comb begin
        w_action = decide(bus.head, bus.left, bus.under, bus.barreira,
                          r_ori, r_x, r_y, r_last_left);
        w_tgt_x  = r_x;
        w_tgt_y  = r_y;
        case (r_ori)
            ORI_N:   w_tgt_y = r_y + Y_W'(1);
            ORI_E:   w_tgt_x = r_x + X_W'(1);
            ORI_S:   w_tgt_y = r_y - Y_W'(1);
            ORI_W:   w_tgt_x = r_x - X_W'(1);
            default: w_tgt_x = r_x;
        endcase
    end

    // Next-state, pose and action-pulse logic
    always_comb begin
        w_state     = r_state;
        w_ori       = r_ori;
        w_x         = r_x;
        w_y         = r_y;
        w_last_left = r_last_left;
        w_turn_cnt  = r_turn_cnt;
        w_avancar   = 1'b0;
        w_girar     = 1'b0;
        w_girar_esq = 1'b0;
        w_remover   = 1'b0;
        w_busy      = r_busy;
        w_done      = r_done;
        w_stuck     = r_stuck;
        w_turn_inc  = (r_turn_cnt == 3'd7) ? r_turn_cnt : r_turn_cnt + 3'd1;
        case (r_state)
            ST_RUN: begin
                if (w_tick) begin
                    case (w_action)
                        ACT_REMOVE: begin
                            w_remover = 1'b1;
                        end
                        ACT_TURN_L: begin
                            w_girar     = 1'b1;
                            w_girar_esq = 1'b1;
                            w_ori       = rot_ccw(r_ori);
                            w_last_left = 1'b1;
                        end
                        ACT_ADV: begin
                            w_avancar   = 1'b1;
                            w_x         = w_tgt_x;
                            w_y         = w_tgt_y;
                            w_last_left = 1'b0;
                            w_turn_cnt  = 3'd0;
                            if ((w_tgt_x == GX) && (w_tgt_y == GY)) begin
                                w_state = ST_DONE;
                                w_busy  = 1'b0;
                                w_done  = 1'b1;
                            end else begin
                                w_state = ST_RUN;
                            end
                        end
                        ACT_TURN_R: begin
                            w_girar     = 1'b1;
                            w_ori       = rot_cw(r_ori);
                            w_last_left = 1'b0;
                            w_turn_cnt  = w_turn_inc;
                            if (w_turn_inc == STUCK_TURNS) begin
                                w_state = ST_STUCK;
                                w_busy  = 1'b0;
                                w_stuck = 1'b1;
                            end else begin
                                w_state = ST_RUN;
                            end
                        end
                        default: begin
                            w_state = ST_RUN;
                        end
                    endcase
                end else begin
                    w_state = ST_RUN;
                end
            end
            ST_IDLE, ST_DONE, ST_STUCK: begin
                if (bus.start) begin
                    w_state     = ST_RUN;
                    w_ori       = ORI_N;
                    w_x         = '0;
                    w_y         = '0;
                    w_turn_cnt  = 3'd0;
                    w_last_left = 1'b0;
                    w_busy      = 1'b1;
                    w_done      = 1'b0;
                    w_stuck     = 1'b0;
                end else begin
                    w_state = r_state;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over everything, including a tick
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ori       <= ORI_N;
            r_x         <= '0;
            r_y         <= '0;
            r_last_left <= 1'b0;
            r_turn_cnt  <= 3'd0;
            r_avancar   <= 1'b0;
            r_girar     <= 1'b0;
            r_girar_esq <= 1'b0;
            r_remover   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_stuck     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_ori       <= w_ori;
            r_x         <= w_x;
            r_y         <= w_y;
            r_last_left <= w_last_left;
            r_turn_cnt  <= w_turn_cnt;
            r_avancar   <= w_avancar;
            r_girar     <= w_girar;
            r_girar_esq <= w_girar_esq;
            r_remover   <= w_remover;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_stuck     <= w_stuck;
        end
    end

    assign bus.avancar    = r_avancar;
    assign bus.girar      = r_girar;
    assign bus.girar_esq  = r_girar_esq;
    assign bus.remover    = r_remover;
    assign bus.orientacao = r_ori;
    assign bus.pos_x      = r_x;
    assign bus.pos_y      = r_y;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.stuck      = r_stuck;
endmodule

// File: tb/tb_maze_walker.sv
// Scoreboard bench for maze_walker: each directed decision queues its expected pulse
// (cycle, pulse bits, pose, flags); a negedge monitor pops and compares every pulse.
module tb_maze_walker;

    typedef struct packed {
        logic [3:0] pulses;   // {avancar, girar, girar_esq, remover}
        logic [2:0] ori;
        logic [2:0] x;
        logic [2:0] y;
        logic [2:0] flags;    // {busy, done, stuck}
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   edge_cnt = 0;
    exp_t exp_q[$];
    exp_t m_exp;
    obs_t m_act;

    always #5 clock = ~clock;

    maze_walker_if #(.X_W(3), .Y_W(3)) bus ();

    maze_walker #(
        .X_W(3), .Y_W(3), .GOAL_X(0), .GOAL_Y(3), .STEP_DIV(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    function automatic obs_t cur();
        cur = {bus.avancar, bus.girar, bus.girar_esq, bus.remover, bus.orientacao,
               bus.pos_x, bus.pos_y, bus.busy, bus.done, bus.stuck};
    endfunction

    function automatic obs_t mk(input logic [3:0] p, input logic [2:0] o,
                                input logic [2:0] x, input logic [2:0] y,
                                input logic [2:0] f);
        mk = {p, o, x, y, f};
    endfunction

    // Monitor: every action pulse must match the head of the scoreboard queue
    always @(negedge clock) begin
        m_act = cur();
        if (m_act.pulses[3] || m_act.pulses[2] || m_act.pulses[0]) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got %h at cycle %0d, required no pulse", m_act, edge_cnt);
            end else begin
                m_exp = exp_q.pop_front();
                if (m_act !== m_exp.o || edge_cnt != m_exp.cyc) begin
                    failures++;
                    $display("FAIL pulse: got %h at cycle %0d, required %h at cycle %0d",
                             m_act, edge_cnt, m_exp.o, m_exp.cyc);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input obs_t e);
        obs_t a;
        a = cur();
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    // One decision window: noise first, real sensors on the tick cycle
    task automatic decide(input logic h, input logic l, input logic u, input logic b,
                          input logic st_mid, input obs_t e);
        exp_q.push_back('{edge_cnt + 4, e});
        bus.head = 1'b1; bus.left = 1'b0; bus.under = 1'b1; bus.barreira = 1'b1;
        bus.start = st_mid;
        cyc();
        bus.start = 1'b0;
        cyc();
        bus.head = h; bus.left = l; bus.under = u; bus.barreira = b;
        cyc();
        cyc();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.head = 1'b0; bus.left = 1'b1;
        bus.under = 1'b0; bus.barreira = 1'b0;
        idle(3);
        check("reset_state", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b000));
        reset = 1'b0;
        idle(6);
        check("idle_after_reset", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b000));

        // Reset landing on a tick mid-run
        do_start();
        check("start_busy", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0110, 3'd3, 3'd0, 3'd0, 3'b100));
        idle(3);
        bus.left = 1'b0; bus.under = 1'b0; bus.head = 1'b0; bus.barreira = 1'b0;
        reset = 1'b1;
        cyc();
        check("reset_on_tick", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b000));
        reset = 1'b0;
        idle(8);
        check("idle_after_midrun_reset", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b000));

        // Open corridor north to goal (0,3)
        do_start();
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd0, 3'd0, 3'd1, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd0, 3'd0, 3'd2, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd0, 3'd0, 3'd3, 3'b010));
        idle(8);
        check("done_held", mk(4'b0000, 3'd0, 3'd0, 3'd3, 3'b010));

        // Left opening, west edge, debris priority, barreira, ignored start, dead end
        do_start();
        check("restart_from_done", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0110, 3'd3, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(4'b0001, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(4'b0110, 3'd3, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd0, 3'd0, 3'd1, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, mk(4'b0100, 3'd1, 3'd0, 3'd1, 3'b100));
        decide(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd2, 3'd0, 3'd1, 3'b100));
        decide(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd3, 3'd0, 3'd1, 3'b100));
        decide(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd0, 3'd0, 3'd1, 3'b001));
        idle(8);
        check("stuck_held", mk(4'b0000, 3'd0, 3'd0, 3'd1, 3'b001));

        // East move, south edge, west move
        do_start();
        check("restart_from_stuck", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b100));
        decide(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd1, 3'd0, 3'd0, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd1, 3'd1, 3'd0, 3'b100));
        decide(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd2, 3'd1, 3'd0, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b0100, 3'd3, 3'd1, 3'd0, 3'b100));
        decide(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(4'b1000, 3'd3, 3'd0, 3'd0, 3'b100));

        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(2);
        check("final_reset", mk(4'b0000, 3'd0, 3'd0, 3'd0, 3'b000));

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_pulses: got %0d still queued, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
